// File: rtl/spi_cmd_dispatch.sv
// spi_cmd_dispatch: frames the decoded SPI write stream into command
// transactions (one command byte plus up to MAX_LEN payload bytes). Each
// complete frame goes to one consumer over a valid/ready handshake.
// Truncated, overrun and colliding frames are dropped and counted.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   pw_wdata/pw_wcmd     received byte; wcmd marks the command byte
//   pw_wstb              one-cycle byte strobe
//   pw_end               one-cycle end-of-frame pulse (CS deassert)
//   cmd_valid/cmd_ready  transaction handshake
//   cmd_code             command byte
//   cmd_len              payload byte count, 0..MAX_LEN
//   cmd_data             payload, right-aligned, last byte in [7:0]
//   drop_cnt             saturating dropped-frame counter
//   busy                 high whenever the FSM is not idle
module spi_cmd_dispatch #(
  parameter int unsigned MAX_LEN = 4,
  localparam int unsigned LW = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           pw_wdata,
  input  logic                 pw_wcmd,
  input  logic                 pw_wstb,
  input  logic                 pw_end,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [7:0]           cmd_code,
  output logic [LW-1:0]        cmd_len,
  output logic [8*MAX_LEN-1:0] cmd_data,
  output logic [7:0]           drop_cnt,
  output logic                 busy
);

  localparam int unsigned DW = 8 * MAX_LEN;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]    state, state_nxt;
  logic          valid_nxt;
  logic [7:0]    code_nxt;
  logic [LW-1:0] len_nxt;
  logic [DW-1:0] data_nxt;
  logic          trunc, trunc_nxt;
  logic          seen, seen_nxt;
  logic          drop_inc;
  logic          cap;

  // Next-state and next-output decode; a byte is processed before a
  // same-cycle end pulse.
  always_comb begin
    state_nxt = state;
    valid_nxt = cmd_valid;
    code_nxt  = cmd_code;
    len_nxt   = cmd_len;
    data_nxt  = cmd_data;
    trunc_nxt = trunc;
    seen_nxt  = seen;
    drop_inc  = 1'b0;
    cap       = 1'b0;

    case (state)
      IDLE: begin
        if (pw_wstb && pw_wcmd) cap = 1'b1;
      end
      RECV: begin
        if (pw_wstb && pw_wcmd) begin
          // Colliding command: abandon the current frame and restart.
          cap      = 1'b1;
          drop_inc = 1'b1;
        end else begin
          if (pw_wstb) begin
            if (cmd_len < LW'(MAX_LEN)) begin
              data_nxt = DW'({cmd_data, pw_wdata});
              len_nxt  = cmd_len + LW'(1);
            end else begin
              trunc_nxt = 1'b1;
            end
          end
          if (pw_end) begin
            if (trunc_nxt) begin
              drop_inc  = 1'b1;
              state_nxt = IDLE;
            end else begin
              valid_nxt = 1'b1;
              state_nxt = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (cmd_ready) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
        if (cmd_ready && pw_wstb && pw_wcmd) begin
          cap = 1'b1;
        end else begin
          // No room for another frame: remember activity, count it at end.
          seen_nxt = seen | pw_wstb;
          if (pw_end && seen_nxt) begin
            drop_inc = 1'b1;
            seen_nxt = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Command-byte capture shared by IDLE, RECV restart and zero-bubble HOLD.
    if (cap) begin
      code_nxt  = pw_wdata;
      len_nxt   = '0;
      data_nxt  = '0;
      trunc_nxt = 1'b0;
      seen_nxt  = 1'b0;
      state_nxt = RECV;
      if (pw_end) begin
        valid_nxt = 1'b1;
        state_nxt = HOLD;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      cmd_len   <= '0;
      cmd_data  <= '0;
      trunc     <= 1'b0;
      seen      <= 1'b0;
      drop_cnt  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_valid <= valid_nxt;
      cmd_code  <= code_nxt;
      cmd_len   <= len_nxt;
      cmd_data  <= data_nxt;
      trunc     <= trunc_nxt;
      seen      <= seen_nxt;
      busy      <= (state_nxt != IDLE);
      if (drop_inc && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
